// File: rtl/reshaper_mc_pkg.sv
// reshaper_mc_pkg: shared cycle-count defaults and lane state encoding for the WS2812 reshaper.
// Rev 1.0
`default_nettype none

package reshaper_mc_pkg;

  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_CNT_W      = 12;
  localparam int DEF_GLITCH_CYC = 3;
  localparam int DEF_T0H_NOM    = 18;
  localparam int DEF_T0H_MAX    = 25;
  localparam int DEF_T1H_MIN    = 30;
  localparam int DEF_T1H_NOM    = 40;
  localparam int DEF_T1H_MAX    = 60;
  localparam int DEF_RESET_CYC  = 2500;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_QUAL  = 3'd1,
    S_HIGH  = 3'd2,
    S_HOLD  = 3'd3,
    S_STUCK = 3'd4
  } ws_state_e;

endpackage

`default_nettype wire

// File: rtl/reshaper_mc_lane.sv
// reshaper_lane: one lane's glitch qualifier, bit classifier, pulse regenerator and frame detector.
// Rev 1.0
`default_nettype none

module reshaper_lane
  import reshaper_mc_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int GLITCH_CYC = DEF_GLITCH_CYC,
  parameter int T0H_NOM    = DEF_T0H_NOM,
  parameter int T0H_MAX    = DEF_T0H_MAX,
  parameter int T1H_MIN    = DEF_T1H_MIN,
  parameter int T1H_NOM    = DEF_T1H_NOM,
  parameter int T1H_MAX    = DEF_T1H_MAX,
  parameter int RESET_CYC  = DEF_RESET_CYC
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_passthru_en,
  input  logic i_signal_synced,
  input  logic i_err_clr,
  output logic o_reshaped_signal,
  output logic o_bit_valid,
  output logic o_bit_value,
  output logic o_frame_end,
  output logic o_err_sticky
);

  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_SAT     = '1;
  localparam logic [CNT_W-1:0] C_GLITCH  = CNT_W'(GLITCH_CYC);
  localparam logic [CNT_W-1:0] C_T0H_NOM = CNT_W'(T0H_NOM);
  localparam logic [CNT_W-1:0] C_T0H_MAX = CNT_W'(T0H_MAX);
  localparam logic [CNT_W-1:0] C_T1H_MIN = CNT_W'(T1H_MIN);
  localparam logic [CNT_W-1:0] C_T1H_NOM = CNT_W'(T1H_NOM);
  localparam logic [CNT_W-1:0] C_STUCK   = CNT_W'(T1H_MAX + 1);
  localparam logic [CNT_W-1:0] C_RESET   = CNT_W'(RESET_CYC);

  ws_state_e        state_q;
  logic [CNT_W-1:0] hcnt_q, ocnt_q, lcnt_q;
  logic [CNT_W-1:0] hcnt_d, ocnt_d, lcnt_d;
  logic             seen_q, out_q, valid_q, value_q, fe_q, err_q;
  logic             is_one, err_set;
  logic [CNT_W-1:0] min_width;

  assign hcnt_d = (hcnt_q == C_SAT) ? hcnt_q : hcnt_q + C_ONE;
  assign ocnt_d = (ocnt_q == C_SAT) ? ocnt_q : ocnt_q + C_ONE;
  assign lcnt_d = (lcnt_q == C_SAT) ? lcnt_q : lcnt_q + C_ONE;

  // hcnt is frozen once the input falls, so it carries the final input width into S_HOLD.
  assign is_one    = (hcnt_q > C_T0H_MAX);
  assign min_width = is_one ? C_T1H_NOM : C_T0H_NOM;

  always_comb begin
    err_set = 1'b0;
    if (i_passthru_en && state_q == S_HIGH) begin
      if (hcnt_q == C_STUCK) begin
        err_set = 1'b1;
      end else if (!i_signal_synced && hcnt_q > C_T0H_MAX && hcnt_q < C_T1H_MIN) begin
        err_set = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      hcnt_q  <= '0;
      ocnt_q  <= '0;
      lcnt_q  <= '0;
      seen_q  <= 1'b0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      value_q <= 1'b0;
      fe_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      value_q <= 1'b0;
      fe_q    <= 1'b0;
      err_q   <= err_set | (err_q & ~i_err_clr);
      lcnt_q  <= i_signal_synced ? '0 : lcnt_d;

      if (!i_passthru_en) begin
        state_q <= S_IDLE;
        out_q   <= 1'b0;
        hcnt_q  <= '0;
        ocnt_q  <= '0;
        lcnt_q  <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            out_q  <= 1'b0;
            ocnt_q <= '0;
            if (lcnt_q == C_RESET && seen_q) begin
              fe_q   <= 1'b1;
              seen_q <= 1'b0;
            end
            if (i_signal_synced) begin
              hcnt_q  <= C_ONE;
              state_q <= S_QUAL;
            end else begin
              hcnt_q <= '0;
            end
          end

          S_QUAL: begin
            if (hcnt_q == C_GLITCH) begin
              state_q <= S_HIGH;
              out_q   <= 1'b1;
              ocnt_q  <= C_ONE;
              if (i_signal_synced) hcnt_q <= hcnt_d;
            end else if (!i_signal_synced) begin
              state_q <= S_IDLE;
            end else begin
              hcnt_q <= hcnt_d;
            end
          end

          S_HIGH: begin
            ocnt_q <= ocnt_d;
            if (hcnt_q == C_STUCK) begin
              state_q <= S_STUCK;
              out_q   <= 1'b0;
              valid_q <= 1'b1;
              value_q <= 1'b1;
              seen_q  <= 1'b1;
            end else if (!i_signal_synced) begin
              if (ocnt_q >= min_width) begin
                state_q <= S_IDLE;
                out_q   <= 1'b0;
                valid_q <= 1'b1;
                value_q <= is_one;
                seen_q  <= 1'b1;
              end else begin
                state_q <= S_HOLD;
              end
            end else begin
              hcnt_q <= hcnt_d;
            end
          end

          // Input activity is ignored here; a new pulse is qualified only from S_IDLE.
          S_HOLD: begin
            if (ocnt_q >= min_width) begin
              state_q <= S_IDLE;
              out_q   <= 1'b0;
              valid_q <= 1'b1;
              value_q <= is_one;
              seen_q  <= 1'b1;
            end else begin
              ocnt_q <= ocnt_d;
            end
          end

          S_STUCK: begin
            out_q  <= 1'b0;
            ocnt_q <= '0;
            if (i_signal_synced) begin
              hcnt_q <= hcnt_d;
            end else begin
              state_q <= S_IDLE;
            end
          end

          default: begin
            state_q <= S_IDLE;
            out_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_reshaped_signal = out_q;
  assign o_bit_valid       = valid_q;
  assign o_bit_value       = value_q;
  assign o_frame_end       = fe_q;
  assign o_err_sticky      = err_q;

endmodule

`default_nettype wire

// File: rtl/reshaper_mc.sv
// reshaper_mc: NUM_CH independent WS2812 reshaper lanes between input synchronisers and LED pins.
// Rev 1.0
`default_nettype none

module reshaper_mc
  import reshaper_mc_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int GLITCH_CYC = DEF_GLITCH_CYC,
  parameter int T0H_NOM    = DEF_T0H_NOM,
  parameter int T0H_MAX    = DEF_T0H_MAX,
  parameter int T1H_MIN    = DEF_T1H_MIN,
  parameter int T1H_NOM    = DEF_T1H_NOM,
  parameter int T1H_MAX    = DEF_T1H_MAX,
  parameter int RESET_CYC  = DEF_RESET_CYC
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [NUM_CH-1:0] i_passthru_en,
  input  logic [NUM_CH-1:0] i_signal_synced,
  input  logic [NUM_CH-1:0] i_err_clr,
  output logic [NUM_CH-1:0] o_reshaped_signal,
  output logic [NUM_CH-1:0] o_bit_valid,
  output logic [NUM_CH-1:0] o_bit_value,
  output logic [NUM_CH-1:0] o_frame_end,
  output logic [NUM_CH-1:0] o_err_sticky
);

  if (!(GLITCH_CYC >= 1 && GLITCH_CYC < T0H_NOM && T0H_NOM <= T0H_MAX &&
        T0H_MAX < T1H_MIN && T1H_MIN <= T1H_NOM && T1H_NOM <= T1H_MAX &&
        T1H_MAX < (1 << CNT_W) && RESET_CYC < (1 << CNT_W))) begin : g_param_check
    $error("reshaper_mc: inconsistent timing parameters");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    reshaper_lane #(
      .CNT_W      (CNT_W),
      .GLITCH_CYC (GLITCH_CYC),
      .T0H_NOM    (T0H_NOM),
      .T0H_MAX    (T0H_MAX),
      .T1H_MIN    (T1H_MIN),
      .T1H_NOM    (T1H_NOM),
      .T1H_MAX    (T1H_MAX),
      .RESET_CYC  (RESET_CYC)
    ) u_lane (
      .i_clk             (i_clk),
      .i_reset_n         (i_reset_n),
      .i_passthru_en     (i_passthru_en[i]),
      .i_signal_synced   (i_signal_synced[i]),
      .i_err_clr         (i_err_clr[i]),
      .o_reshaped_signal (o_reshaped_signal[i]),
      .o_bit_valid       (o_bit_valid[i]),
      .o_bit_value       (o_bit_value[i]),
      .o_frame_end       (o_frame_end[i]),
      .o_err_sticky      (o_err_sticky[i])
    );
  end

endmodule

`default_nettype wire
